// File: rtl/contra_boulder_palette_encoder.sv
// contra_boulder_palette_encoder
//   Inverse of the boulder-tile palette lookup: maps a 12-bit 4:4:4 RGB
//   pixel to the 3-bit index of the nearest of the 8 fixed boulder palette
//   entries, using the sum of absolute channel differences (SAD).
//   Serial search, one palette entry per clock, valid/ready on both sides.
//
//   Optional feature macro: PAL_ENC_EARLY_EXIT_EN
//     defined   - the search stops as soon as an entry matches exactly (dist 0)
//     undefined - all 8 entries are always evaluated (fixed latency of 9)
//
// Ports
//   Clk        in   1       system clock, rising edge
//   Reset      in   1       asynchronous, active-high reset
//   in_valid   in   1       in_rgb valid
//   in_ready   out  1       encoder can accept a pixel (IDLE only)
//   in_rgb     in   12      {red,green,blue}, 4 bits each
//   out_valid  out  1       result valid, held until accepted
//   out_ready  in   1       downstream accepts result
//   out_index  out  IDX_W   nearest palette index
//   out_dist   out  DIST_W  SAD distance of the chosen entry
module contra_boulder_palette_encoder #(
  parameter int COLOR_W = 4,
  parameter int IDX_W   = 3,
  parameter int DIST_W  = 6
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3*COLOR_W-1:0]   in_rgb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  output logic [DIST_W-1:0]      out_dist
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  // Boulder palette, {R,G,B} 4 bits each, indexed by palette entry.
  localparam logic [11:0] PAL [8] = '{
    12'h760, 12'h320, 12'hEB3, 12'h000,
    12'h870, 12'h210, 12'hDA3, 12'h430
  };

  state_t                 r_state;
  state_t                 w_next;
  logic [3*COLOR_W-1:0]   r_rgb;
  logic [IDX_W-1:0]       r_cnt;
  logic                   r_issue_done;
  // Pipeline stage between distance calculation and best-so-far compare.
  logic                   r_pvalid;
  logic [DIST_W-1:0]      r_pdist;
  logic [IDX_W-1:0]       r_pidx;
  logic [DIST_W-1:0]      r_best_dist;
  logic [IDX_W-1:0]       r_best_idx;

  logic [11:0]            w_entry;
  logic [DIST_W-1:0]      w_dist;
  logic                   w_zero_exit;

  function automatic logic [DIST_W-1:0] f_absdiff(input logic [3:0] a,
                                                  input logic [3:0] b);
    logic [3:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return DIST_W'(d);
  endfunction

  assign w_entry = PAL[r_cnt];
  assign w_dist  = f_absdiff(r_rgb[11:8], w_entry[11:8])
                 + f_absdiff(r_rgb[7:4],  w_entry[7:4])
                 + f_absdiff(r_rgb[3:0],  w_entry[3:0]);

`ifdef PAL_ENC_EARLY_EXIT_EN
  assign w_zero_exit = r_pvalid && (r_pdist == '0);
`else
  assign w_zero_exit = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_rgb        <= '0;
      r_cnt        <= '0;
      r_issue_done <= 1'b0;
      r_pvalid     <= 1'b0;
      r_pdist      <= '0;
      r_pidx       <= '0;
      r_best_dist  <= '0;
      r_best_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rgb        <= in_rgb;
            r_cnt        <= '0;
            r_issue_done <= 1'b0;
            r_pvalid     <= 1'b0;
            r_best_dist  <= '1;
            r_best_idx   <= '0;
          end
        end
        S_SEARCH: begin
          // Stage 1: distance of entry r_cnt; stage 2: strict-less compare,
          // so ties keep the lower index already held in r_best_idx.
          r_pvalid <= !r_issue_done;
          r_pdist  <= w_dist;
          r_pidx   <= r_cnt;
          if (r_cnt == '1) r_issue_done <= 1'b1;
          else             r_cnt        <= r_cnt + 1'b1;
          if (r_pvalid && (r_pdist < r_best_dist)) begin
            r_best_dist <= r_pdist;
            r_best_idx  <= r_pidx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_SEARCH;
      end
      S_SEARCH: begin
        if (r_pvalid && ((r_pidx == '1) || w_zero_exit)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_index = r_best_idx;
  assign out_dist  = r_best_dist;

endmodule
